// File: rtl/simm_dram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// simm_ctrl_pkg
// Shared definitions for the SIMM DRAM sequencing controller.
//   - controller state encoding
//   - address field widths and slice positions (bank / row / column)
//   - data width and number of RAS lines
//   - small helper functions used at elaboration and in the datapath
// Optional feature macro used by the controller: SIMM_CTRL_REFRESH_EN.
// -----------------------------------------------------------------------------
package simm_ctrl_pkg;

    localparam int BANK_W   = 3;
    localparam int ROW_W    = 9;
    localparam int COL_W    = 9;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = BANK_W + ROW_W + COL_W;
    localparam int NUM_RAS  = 1 << BANK_W;

    // Word address layout: [20:18] RAS line, [17:9] row, [8:0] column.
    localparam int COL_LSB  = 0;
    localparam int ROW_LSB  = COL_W;
    localparam int BANK_LSB = COL_W + ROW_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROW,
        ST_COL,
        ST_PRE,
        ST_REF_CAS,
        ST_REF_RAS,
        ST_REF_PRE
    } state_t;

    // Active-low one-hot RAS pattern for the selected line.
    function automatic logic [NUM_RAS-1:0] ras_onehot_n(input logic [BANK_W-1:0] bank);
        return ~({{(NUM_RAS-1){1'b0}}, 1'b1} << bank);
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/simm_dram_ctrl_if.sv
// -----------------------------------------------------------------------------
// simm_dram_ctrl_if
// Request/acknowledge bus between the system bus logic (master) and the SIMM
// DRAM controller (slave).
//   req   : access request, held until ack
//   wr    : 1 = write, 0 = read
//   addr  : word address {RAS line, row, column}
//   wdata : write data
//   be    : byte enables (bit 1 = upper byte)
//   ack   : one-cycle completion pulse
//   rdata : read data, valid while ack is high
// -----------------------------------------------------------------------------
interface simm_dram_ctrl_if;
    import simm_ctrl_pkg::*;

    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        be;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, wr, addr, wdata, be, input  ack, rdata);
    modport slave  (input  req, wr, addr, wdata, be, output ack, rdata);

endinterface

// File: rtl/simm_refresh_timer.sv
// -----------------------------------------------------------------------------
// simm_refresh_timer
// Refresh interval counter for the SIMM DRAM controller. Only instantiated
// when SIMM_CTRL_REFRESH_EN is defined.
//   clk, rst        : clock, asynchronous active-high reset
//   i_ref_start     : controller is entering the refresh sequence this edge
//   o_ref_pending   : one refresh is owed
//   o_ref_miss      : sticky, an interval expired while a refresh was owed
// -----------------------------------------------------------------------------
module simm_refresh_timer #(
    parameter int REFRESH_INTERVAL = 780
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ref_start,
    output logic o_ref_pending,
    output logic o_ref_miss
);

    localparam int               TMR_W    = $clog2(REFRESH_INTERVAL);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REFRESH_INTERVAL - 1);

    logic [TMR_W-1:0] r_timer;
    logic             r_pending;
    logic             r_miss;
    logic             w_wrap;

    assign w_wrap = (r_timer == TMR_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer   <= '0;
            r_pending <= 1'b0;
            r_miss    <= 1'b0;
        end else begin
            r_timer <= w_wrap ? '0 : r_timer + 1'b1;
            // A wrap on the same edge as the refresh start re-arms the flag:
            // the new interval owes its own refresh.
            if (w_wrap)
                r_pending <= 1'b1;
            else if (i_ref_start)
                r_pending <= 1'b0;
            // Only one refresh is ever owed; a second expiry is a miss.
            if (w_wrap && r_pending && !i_ref_start)
                r_miss <= 1'b1;
        end
    end

    assign o_ref_pending = r_pending;
    assign o_ref_miss    = r_miss;

endmodule

// File: rtl/simm_dram_ctrl.sv
// -----------------------------------------------------------------------------
// simm_dram_ctrl
// Sequencing controller for the four-SIMM, eight-RAS-line DRAM array. Turns
// word requests from the bus into RAS/CAS/WE strobes, a multiplexed row/column
// address and data-bus enables, and issues periodic CAS-before-RAS refresh.
// Optional feature: SIMM_CTRL_REFRESH_EN enables the refresh timer, the REF_*
// states and ref_miss; without it ref_miss is tied low and no refresh runs.
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   bus        : slave side of simm_dram_ctrl_if (req/wr/addr/wdata/be/ack/rdata)
//   ras_n      : per-line RAS strobes, active low
//   cas_n      : per-byte CAS strobes, active low
//   we_n       : write enable, active low
//   dram_addr  : multiplexed row/column address
//   dq_out     : write data to array, dq_oe : drive enable for dq_out
//   dq_in      : read data from array
//   ref_miss   : sticky refresh-overrun flag
// All outputs are registered.
// -----------------------------------------------------------------------------
module simm_dram_ctrl
    import simm_ctrl_pkg::*;
#(
    parameter int T_RCD            = 2,
    parameter int T_CAS            = 2,
    parameter int T_RAS            = 3,
    parameter int T_RP             = 2,
    parameter int REFRESH_INTERVAL = 780
) (
    input  logic                 clk,
    input  logic                 rst,
    simm_dram_ctrl_if.slave      bus,
    output logic [NUM_RAS-1:0]   ras_n,
    output logic [1:0]           cas_n,
    output logic                 we_n,
    output logic [ROW_W-1:0]     dram_addr,
    output logic [DATA_W-1:0]    dq_out,
    output logic                 dq_oe,
    input  logic [DATA_W-1:0]    dq_in,
    output logic                 ref_miss
);

    if (T_RCD < 1 || T_CAS < 1 || T_RAS < 1 || T_RP < 1 || REFRESH_INTERVAL < 16) begin : g_param_check
        $error("simm_dram_ctrl: timing parameter out of range");
    end

    localparam int CNT_MAX = max4(T_RCD, T_CAS, T_RAS, T_RP);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_wr;
    logic [COL_W-1:0]    r_col;
    logic [DATA_W-1:0]   r_wdata;
    logic [1:0]          r_be;

    logic [NUM_RAS-1:0]  r_ras_n;
    logic [1:0]          r_cas_n;
    logic                r_we_n;
    logic [ROW_W-1:0]    r_dram_addr;
    logic [DATA_W-1:0]   r_dq_out;
    logic                r_dq_oe;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_ack;

    logic                w_ref_pending;
    logic                w_cnt_done;
    logic                w_decide;
    logic                w_ref_go;
    logic                w_accept;

`ifdef SIMM_CTRL_REFRESH_EN
    simm_refresh_timer #(
        .REFRESH_INTERVAL (REFRESH_INTERVAL)
    ) u_refresh (
        .clk           (clk),
        .rst           (rst),
        .i_ref_start   (w_ref_go),
        .o_ref_pending (w_ref_pending),
        .o_ref_miss    (ref_miss)
    );
`else
    assign w_ref_pending = 1'b0;
    assign ref_miss      = 1'b0;
`endif

    assign w_cnt_done = (r_cnt == '0);

    // The last precharge cycle doubles as an IDLE decision slot, so a new
    // access (or refresh) can start without an extra dead cycle.
    assign w_decide = (r_state == ST_IDLE) ||
                      ((r_state == ST_PRE || r_state == ST_REF_PRE) && w_cnt_done);
    assign w_ref_go = w_decide && w_ref_pending;
    assign w_accept = w_decide && !w_ref_pending && bus.req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_wr        <= 1'b0;
            r_col       <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_ras_n     <= '1;
            r_cas_n     <= '1;
            r_we_n      <= 1'b1;
            r_dram_addr <= '0;
            r_dq_out    <= '0;
            r_dq_oe     <= 1'b0;
            r_rdata     <= '0;
            r_ack       <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            if (w_ref_go) begin
                r_state <= ST_REF_CAS;
                r_ras_n <= '1;
                r_cas_n <= 2'b00;
                r_we_n  <= 1'b1;
                r_dq_oe <= 1'b0;
            end else if (w_accept) begin
                r_state     <= ST_ROW;
                r_cnt       <= CNT_W'(T_RCD - 1);
                r_wr        <= bus.wr;
                r_col       <= bus.addr[COL_LSB +: COL_W];
                r_wdata     <= bus.wdata;
                r_be        <= bus.be;
                r_ras_n     <= ras_onehot_n(bus.addr[BANK_LSB +: BANK_W]);
                r_dram_addr <= bus.addr[ROW_LSB +: ROW_W];
                r_cas_n     <= '1;
                r_we_n      <= 1'b1;
                r_dq_oe     <= 1'b0;
            end else begin
                case (r_state)
                    ST_ROW: begin
                        if (w_cnt_done) begin
                            r_state     <= ST_COL;
                            r_cnt       <= CNT_W'(T_CAS - 1);
                            r_dram_addr <= r_col;
                            // be=00 still runs the cycle, just with CAS idle.
                            r_cas_n     <= ~r_be;
                            r_we_n      <= ~r_wr;
                            r_dq_oe     <= r_wr;
                            if (r_wr)
                                r_dq_out <= r_wdata;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    ST_COL: begin
                        if (w_cnt_done) begin
                            r_state <= ST_PRE;
                            r_cnt   <= CNT_W'(T_RP - 1);
                            r_ras_n <= '1;
                            r_cas_n <= '1;
                            r_we_n  <= 1'b1;
                            r_dq_oe <= 1'b0;
                            r_ack   <= 1'b1;
                            if (!r_wr)
                                r_rdata <= dq_in;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    ST_PRE, ST_REF_PRE: begin
                        if (w_cnt_done)
                            r_state <= ST_IDLE;
                        else
                            r_cnt <= r_cnt - 1'b1;
                    end
`ifdef SIMM_CTRL_REFRESH_EN
                    ST_REF_CAS: begin
                        r_state <= ST_REF_RAS;
                        r_cnt   <= CNT_W'(T_RAS - 1);
                        r_ras_n <= '0;
                    end
                    ST_REF_RAS: begin
                        if (w_cnt_done) begin
                            r_state <= ST_REF_PRE;
                            r_cnt   <= CNT_W'(T_RP - 1);
                            r_ras_n <= '1;
                            r_cas_n <= '1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
`endif
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign ras_n     = r_ras_n;
    assign cas_n     = r_cas_n;
    assign we_n      = r_we_n;
    assign dram_addr = r_dram_addr;
    assign dq_out    = r_dq_out;
    assign dq_oe     = r_dq_oe;
    assign bus.ack   = r_ack;
    assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_simm_dram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_simm_dram_ctrl
// Directed bench for simm_dram_ctrl (default timing) plus a second instance
// with a long row phase and a short refresh interval for the overrun case.
// Refresh-dependent expectations follow SIMM_CTRL_REFRESH_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_simm_dram_ctrl;
    import simm_ctrl_pkg::*;

`ifdef SIMM_CTRL_REFRESH_EN
    localparam int   REF_DLY  = 6;
    localparam logic EXP_MISS = 1'b1;
`else
    localparam int   REF_DLY  = 0;
    localparam logic EXP_MISS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    simm_dram_ctrl_if bus();
    simm_dram_ctrl_if bus2();

    logic [7:0]  ras_n,  ras_n2;
    logic [1:0]  cas_n,  cas_n2;
    logic        we_n,   we_n2;
    logic [8:0]  dram_addr, dram_addr2;
    logic [15:0] dq_out, dq_out2;
    logic        dq_oe,  dq_oe2;
    logic [15:0] dq_in,  dq_in2;
    logic        ref_miss, ref_miss2;

    simm_dram_ctrl u_dut (
        .clk (clk), .rst (rst), .bus (bus),
        .ras_n (ras_n), .cas_n (cas_n), .we_n (we_n), .dram_addr (dram_addr),
        .dq_out (dq_out), .dq_oe (dq_oe), .dq_in (dq_in), .ref_miss (ref_miss)
    );

    simm_dram_ctrl #(.T_RCD (40), .REFRESH_INTERVAL (16)) u_ovr (
        .clk (clk), .rst (rst), .bus (bus2),
        .ras_n (ras_n2), .cas_n (cas_n2), .we_n (we_n2), .dram_addr (dram_addr2),
        .dq_out (dq_out2), .dq_oe (dq_oe2), .dq_in (dq_in2), .ref_miss (ref_miss2)
    );

    // Edges since reset release; equals the refresh timer value modulo the interval.
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        logic        wr;
        logic [15:0] rdata;
        int          ack_cyc;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_ras"}, 32'(ras_n), 32'hFF);
        chk({tag, "_cas"}, 32'(cas_n), 32'h3);
        chk({tag, "_we"},  32'(we_n),  32'h1);
        chk({tag, "_oe"},  32'(dq_oe), 32'h0);
        chk({tag, "_ack"}, 32'(bus.ack), 32'h0);
    endtask

    task automatic check_reset(input string tag);
        check_idle(tag);
        chk({tag, "_dq"},    32'(dq_out), 32'h0);
        chk({tag, "_addr"},  32'(dram_addr), 32'h0);
        chk({tag, "_miss"},  32'(ref_miss), 32'h0);
        chk({tag, "_miss2"}, 32'(ref_miss2), 32'h0);
    endtask

    // Entered at the REF_CAS cycle; leaves at the last REF_PRE cycle.
    task automatic check_refresh(input string tag);
        chk({tag, "_refcas_cas"}, 32'(cas_n), 32'h0);
        chk({tag, "_refcas_ras"}, 32'(ras_n), 32'hFF);
        chk({tag, "_refcas_we"},  32'(we_n),  32'h1);
        chk({tag, "_refcas_ack"}, 32'(bus.ack), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk({tag, "_refras_ras"}, 32'(ras_n), 32'h00);
            chk({tag, "_refras_cas"}, 32'(cas_n), 32'h0);
            chk({tag, "_refras_ack"}, 32'(bus.ack), 32'h0);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            check_idle({tag, "_refpre"});
        end
    endtask

    // Called at mid-cycle of an idle cycle ("cycle 0"); returns in the idle
    // cycle after precharge. extra = cycles of refresh expected ahead of it.
    task automatic access(input logic w, input logic [20:0] a, input logic [15:0] d,
                          input logic [1:0] b, input logic [15:0] rd, input int extra);
        exp_t        e;
        logic [7:0]  eras;
        logic [1:0]  ecas;
        logic        ewe;
        int          n;
        e.wr = w; e.rdata = rd; e.ack_cyc = cyc + 5 + extra;
        sb.push_back(e);
        eras = 8'hFF;
        eras[a[20:18]] = 1'b0;
        ecas = ~b;
        ewe  = ~w;
        bus.req = 1'b1; bus.wr = w; bus.addr = a; bus.wdata = d; bus.be = b;
        step();
        if (extra != 0) begin
            check_refresh("coll");
            step();
        end
        for (int i = 0; i < 2; i++) begin
            chk("row_ras",  32'(ras_n), 32'(eras));
            chk("row_addr", 32'(dram_addr), 32'(a[17:9]));
            chk("row_cas",  32'(cas_n), 32'h3);
            chk("row_ack",  32'(bus.ack), 32'h0);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            dq_in = (i == 0) ? ~rd : rd;
            chk("col_ras",  32'(ras_n), 32'(eras));
            chk("col_addr", 32'(dram_addr), 32'(a[8:0]));
            chk("col_cas",  32'(cas_n), 32'(ecas));
            chk("col_we",   32'(we_n), 32'(ewe));
            chk("col_oe",   32'(dq_oe), 32'(w));
            if (w) chk("col_dq", 32'(dq_out), 32'(d));
            step();
        end
        dq_in = 16'h0000;
        n = 0;
        while (bus.ack !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        e = sb.pop_front();
        chk("ack_seen", 32'(bus.ack), 32'h1);
        chk("ack_cyc",  32'(cyc), 32'(e.ack_cyc));
        if (!e.wr) chk("rdata", 32'(bus.rdata), 32'(e.rdata));
        chk("pre_ras", 32'(ras_n), 32'hFF);
        chk("pre_oe",  32'(dq_oe), 32'h0);
        bus.req = 1'b0;
        step();
        chk("ack_pulse", 32'(bus.ack), 32'h0);
        chk("pre2_cas",  32'(cas_n), 32'h3);
        step();
        check_idle("post");
    endtask

    initial begin
        int  n;
        logic seen;
        rst = 1'b1;
        bus.req = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0; bus.be = '0;
        bus2.req = 1'b0; bus2.wr = 1'b0; bus2.addr = '0; bus2.wdata = '0; bus2.be = '0;
        dq_in = '0; dq_in2 = '0;
        repeat (3) step();
        check_reset("rst0");
        chk("rst0_rdata", 32'(bus.rdata), 32'h0);
        rst = 1'b0;

        // Read with per-phase strobe/address checks.
        access(1'b0, 21'h0A_0203, 16'h0000, 2'b11, 16'hBEEF, 0);
        // Write, lower byte only.
        access(1'b1, 21'h1C_1234, 16'h1234, 2'b01, 16'h0000, 0);
        // No byte enables: full sequence, CAS idle, normal ack.
        access(1'b0, 21'h05_5555, 16'h0000, 2'b00, 16'hA5A5, 0);
        // Upper byte write on a different line.
        access(1'b1, 21'h00_01FF, 16'h8001, 2'b10, 16'h0000, 0);

        // Idle until the first interval expires.
        while (cyc < 780) step();
        chk("ref_wait_cyc", 32'(cyc), 32'd780);
        step();
`ifdef SIMM_CTRL_REFRESH_EN
        check_refresh("ref");
`else
        check_idle("noref");
`endif
        chk("ref_miss_a", 32'(ref_miss), 32'h0);

        // Request rises in the cycle the second refresh becomes pending.
        while (cyc < 1560) step();
        access(1'b0, 21'h13_0F0F, 16'h0000, 2'b11, 16'h5A5A, REF_DLY);
        chk("ref_miss_b", 32'(ref_miss), 32'h0);

        // Long row phase on the second instance spans several short intervals.
        bus2.req = 1'b1; bus2.wr = 1'b0; bus2.addr = 21'h01_2345; bus2.be = 2'b11;
        n = 0;
        while (bus2.ack !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk("ovr_ack", 32'(bus2.ack), 32'h1);
        bus2.req = 1'b0;
        chk("ovr_miss", 32'(ref_miss2), 32'(EXP_MISS));
        chk("main_miss", 32'(ref_miss), 32'h0);
        step();

        // Reset in the middle of a write's column phase.
        bus.req = 1'b1; bus.wr = 1'b1; bus.addr = 21'h0C_0ABC; bus.wdata = 16'hCAFE; bus.be = 2'b11;
        repeat (3) step();
        chk("mid_we", 32'(we_n), 32'h0);
        chk("mid_oe", 32'(dq_oe), 32'h1);
        chk("mid_dq", 32'(dq_out), 32'hCAFE);
        rst = 1'b1;
        bus.req = 1'b0;
        #1;
        check_reset("rst1");
        repeat (2) step();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.ack === 1'b1) seen = 1'b1;
        end
        chk("rst_noack", 32'(seen), 32'h0);
        check_idle("rst_end");
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/simm_dram_ctrl.md
# simm_dram_ctrl

Sequencing controller for the four-SIMM, eight-RAS-line DRAM array: accepts word read/write requests on a simple req/ack handshake and produces the RAS/CAS/WE strobes, the multiplexed row/column address and the data-bus enables. It sits between the system bus logic and the SIMM array top level. It also generates periodic CAS-before-RAS refresh.

## Interface
- T_RCD, 2: cycles RAS is held before CAS (row phase length), ≥1
- T_CAS, 2: cycles CAS is held (column phase length), ≥1
- T_RAS, 3: cycles all RAS lines are held low during refresh, ≥1
- T_RP, 2: precharge cycles after every access or refresh, ≥1
- REFRESH_INTERVAL, 780: cycles between refresh requests, ≥16
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  access request, held until ack
- wr  in  1  1 = write, 0 = read; sampled with req
- addr  in  21  word address: [20:18] RAS line, [17:9] row, [8:0] column
- wdata  in  16  write data, sampled with req
- be  in  2  byte enables (bit 1 = upper byte), sampled with req
- ack  out  1  one-cycle completion pulse
- rdata  out  16  read data, valid while ack is high
- ras_n  out  8  per-line RAS strobes, active low
- cas_n  out  2  per-byte CAS strobes, active low
- we_n  out  1  write enable, active low
- dram_addr  out  9  multiplexed row/column address
- dq_out  out  16  write data to array
- dq_oe  out  1  drive enable for dq_out
- dq_in  in  16  read data from array
- ref_miss  out  1  sticky: refresh interval expired while a refresh was still pending

## Operation
- States: IDLE, ROW, COL, PRE, REF_CAS, REF_RAS, REF_PRE.
- IDLE: all strobes high, dq_oe=0. A pending refresh takes priority, so with ref_pending the FSM goes to REF_CAS even if req=1. Otherwise, if req=1, latch addr/wr/wdata/be and go to ROW.
- ROW (T_RCD cycles): dram_addr=row, ras_n[addr[20:18]]=0 (one-hot low, others high).
- COL (T_CAS cycles): selected RAS stays low; dram_addr=column; cas_n=~be. For writes, we_n=0, dq_oe=1 and dq_out=wdata throughout COL. For reads, rdata is captured from dq_in on the last COL edge.
- PRE (T_RP cycles): all strobes high, dq_oe=0. ack=1 in the first PRE cycle only. Then back to IDLE.
- be=2'b00: the access still runs all phases with cas_n held high and acks normally.
- Refresh timer: counts to REFRESH_INTERVAL-1, wraps to 0 and sets ref_pending. ref_pending clears on entry to REF_CAS. If the timer wraps while ref_pending is already set, ref_miss is set and stays set until reset. Only one refresh is ever owed.
- REF_CAS (1 cycle): cas_n=2'b00, ras_n all high, we_n=1.
- REF_RAS (T_RAS cycles): ras_n=8'h00, cas_n held low.
- REF_PRE (T_RP cycles): all strobes high, then IDLE. No ack is issued for refresh.
- Requests are never dropped. A req arriving during refresh waits in IDLE.

## Timing
- Reset values: ras_n=8'hFF, cas_n=2'b11, we_n=1, dq_oe=0, dq_out=0, dram_addr=0, rdata=0, ack=0, ref_miss=0, timer=0, ref_pending=0, state IDLE.
- Reset asserted mid-access forces all outputs to their reset values immediately (asynchronously). The access is abandoned and never acked.
- Cycle numbering (defaults): req sampled at the end of cycle 0, ROW is cycles 1–2, COL is cycles 3–4, ack is in cycle 5, PRE is cycles 5–6, and IDLE is cycle 7.
- Ack latency is T_RCD+T_CAS+1 cycles after the accepting edge. The earliest next accept is at the end of cycle T_RCD+T_CAS+T_RP.
- The requester must drop req in the cycle after ack unless it is issuing a new request.
- Refresh occupancy: 1+T_RAS+T_RP cycles (6 with defaults).
- All outputs are registered; no combinational path from req to strobes.

## Configuration
- SIMM_CTRL_REFRESH_EN defined: refresh timer, the REF_* states and ref_miss logic are present as described.
- Undefined: no timer, no REF_* states, and ref_pending is constantly 0. ref_miss is tied to 0; every other behaviour is unchanged.

## Structure
- Package simm_ctrl_pkg holds:
  - the state enum;
  - BANK_W=3, ROW_W=9, COL_W=9 and DATA_W=16;
  - the address field slice positions.
- Sub-module simm_refresh_timer contains the interval counter, the ref_pending flag and ref_miss. It is instantiated only under SIMM_CTRL_REFRESH_EN.

## Test plan
- Read: addr=21'h0A_0203, dq_in=16'hBEEF at COL. Expect ras_n=8'hFB in cycles 1–4, dram_addr=9'h101 in ROW and 9'h003 in COL, ack in cycle 5, rdata=16'hBEEF.
- Write: wr=1, be=2'b01, wdata=16'h1234. Expect cas_n=2'b10, we_n=0, dq_oe=1 and dq_out=16'h1234 during COL; dq_oe=0 in PRE; ack in cycle 5.
- Refresh: idle for REFRESH_INTERVAL cycles. Expect REF_CAS with cas_n=00 and ras_n=FF, then ras_n=8'h00 for 3 cycles, then all strobes high for 2 cycles, and no ack.
- Collision: req rises in the same cycle ref_pending sets. Expect the refresh sequence first, then the access acked 6 cycles later than without the refresh.
- Overrun and reset: hold a request stream so that two intervals expire before refresh runs, and expect ref_miss=1. Then assert rst during COL of a write. Expect all strobes high and dq_oe=0 immediately, ack never asserted, and ref_miss=0.
